// File: rtl/rca_seq_ctrl_if.sv
// Request/result bundle for the rca_seq_ctrl sequential adder.
// With RCA_SEQ_SUB_EN defined the bundle also carries the sub request bit.
interface rca_seq_ctrl_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef RCA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    // Requester side: drives operands, observes status and result
    modport master (
        output start, a, b,
`ifdef RCA_SEQ_SUB_EN
        output sub,
`endif
        input  ready, busy, done, sum, cout, ovf
    );

    // Adder side
    modport slave (
        input  start, a, b,
`ifdef RCA_SEQ_SUB_EN
        input  sub,
`endif
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Sequential N-bit adder built from one W-bit ripple-carry slice reused
// over N/W cycles. A registered carry links the chunks.
// Optional feature macro: RCA_SEQ_SUB_EN (adds the sub input for a - b).
module rca_seq_ctrl #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_seq_ctrl_if.slave      bus
);
    localparam int unsigned K     = N / W;
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

    // Reject illegal slice geometries at elaboration
    generate
        if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
            $error("rca_seq_ctrl: N must be a non-zero multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               ready_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [N-1:0]       a_r;
    logic [N-1:0]       b_r;
    logic [N-1:0]       sum_r;
    logic [N-1:0]       sum_shift;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic [W:0]         slice;
    logic               accept;
    logic               last;
    logic [N-1:0]       b_in;
    logic               carry_init;

    assign accept = (state == S_IDLE) && bus.start;
    assign last   = (state == S_RUN) && (cnt == CNT_W'(K - 1));

    // Operand conditioning: subtraction is a + ~b + 1
`ifdef RCA_SEQ_SUB_EN
    assign b_in       = bus.sub ? ~bus.b : bus.b;
    assign carry_init = bus.sub;
`else
    assign b_in       = bus.b;
    assign carry_init = 1'b0;
`endif

    // The single W-bit ripple-carry slice
    assign slice = {1'b0, a_r[W-1:0]} + {1'b0, b_r[W-1:0]} + (W + 1)'(carry_r);

    // Slice result enters the partial sum from the MSB end
    generate
        if (W == N) begin : g_full
            assign sum_shift = slice[W-1:0];
        end else begin : g_chunk
            assign sum_shift = {slice[W-1:0], sum_r[N-1:W]};
        end
    endgenerate

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus.ready <= ready_nxt;
            bus.busy  <= busy_nxt;
            bus.done  <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last)      state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Status decode from the upcoming state so the outputs are registered
    always_comb begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            S_IDLE:  ready_nxt = 1'b1;
            S_RUN:   busy_nxt  = 1'b1;
            S_DONE:  done_nxt  = 1'b1;
            default: ready_nxt = 1'b0;
        endcase
    end

    // Operand shift registers, carry, chunk counter and partial sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else if (accept) begin
            a_r     <= bus.a;
            b_r     <= b_in;
            carry_r <= carry_init;
            cnt     <= '0;
            a_msb   <= bus.a[N-1];
            b_msb   <= b_in[N-1];
        end else if (state == S_RUN) begin
            a_r     <= a_r >> W;
            b_r     <= b_r >> W;
            sum_r   <= sum_shift;
            carry_r <= slice[W];
            cnt     <= cnt + CNT_W'(1);
        end
    end

    // Visible result: updated only on the final chunk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (last) begin
            bus.sum  <= sum_shift;
            bus.cout <= slice[W];
            bus.ovf  <= (a_msb == b_msb) && (sum_shift[N-1] != a_msb);
        end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (N=32, W=8, K=4).
module tb_rca_seq_ctrl;
    localparam int K = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    rca_seq_ctrl_if #(.N(32)) bus ();

    rca_seq_ctrl #(.N(32), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",     bus.sum, e.sum);
                check("cout",    32'(bus.cout), 32'(e.cout));
                check("ovf",     32'(bus.ovf), 32'(e.ovf));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] esum, input logic ecout, input logic eovf,
                          input bit poke);
        exp_t e;
        int   waited;
        bit   got;
        @(negedge clk);
        check("ready_idle", 32'(bus.ready), 32'd1);
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        e.cyc  = cyc + 1 + K;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef RCA_SEQ_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub requested in add-only build");
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        check("busy_run",  32'(bus.busy), 32'd1);
        check("ready_run", 32'(bus.ready), 32'd0);
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready) begin
                got    = 1'b1;
                waited = i;
                break;
            end
            if (poke) begin
                bus.start = bus.busy || bus.done;
                bus.a     = 32'h55;
                bus.b     = 32'h66;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ready_returned", 32'(got), 32'd1);
        check("ready_spacing",  32'(waited), 32'(K + 1));
        check("done_seen",      32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef RCA_SEQ_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_sum",   bus.sum,        32'd0);
        check("rst_cout",  32'(bus.cout),  32'd0);
        check("rst_ovf",   32'(bus.ovf),   32'd0);
        rst_n = 1'b1;

        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0, 1'b0);

        // start pulses during RUN and DONE must be ignored
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("no_second_op", 32'(bus.busy), 32'd0);
        check("sum_held",     bus.sum,       32'h0000_0030);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hAAAA_AAAA;
        bus.b     = 32'h1111_1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_busy",  32'(bus.busy),  32'd0);
        check("abort_done",  32'(bus.done),  32'd0);
        check("abort_sum",   bus.sum,        32'd0);
        check("abort_cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_idle", 32'(bus.ready), 32'd1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(32'h0000_0009, 32'h0000_0003, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
